// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI bus arbiter
//
// Purpose : arbiter FSM state encoding and default SPI word width.
// Ports   : none (package).

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } arb_state_t;

  localparam int SPI_DW = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose : selects the first set req bit at or after ptr, wrapping modulo N.
// Ports   :
//   req     in   N    request vector
//   ptr     in   PW   index with highest priority this cycle (must be < N)
//   onehot  out  N    one-hot winner, zero when no request
//   idx     out  PW   binary winner index, zero when no request
//   valid   out  1    at least one request present

module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int j;

  // Scan from the lowest priority offset to the highest so the last hit,
  // which is the one closest to ptr, is the one that sticks.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arb.sv
// rtl/spi_bus_arb.sv - round-robin arbiter sharing one SPI master between requesters
//
// Purpose : grants the SPI master to one requester at a time, issues one spi_wrt
//           per transaction, returns done/read data, supports capped locked bursts
//           and aborts transactions whose done never arrives.
// Ports   :
//   clk, rst_n     clock, asynchronous active-low reset
//   req, lock      per-requester level request / keep-bus flag (lock sampled at done)
//   cmd_in         packed commands, requester i at [i*DW +: DW]
//   gnt            registered one-hot grant
//   req_done       1-cycle completion pulse to the owner
//   req_err        1-cycle watchdog-abort pulse to the owner (together with req_done)
//   rd_data        read data of the last transaction (0 after an abort)
//   spi_wrt        1-cycle start pulse to the SPI master
//   spi_cmd        command latched for the SPI master
//   spi_done       SPI master completion
//   spi_rd_data    SPI master read data

module spi_bus_arb
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DW          = SPI_DW,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ*DW-1:0] cmd_in,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [DW-1:0]         rd_data,
  output logic                  spi_wrt,
  output logic [DW-1:0]         spi_cmd,
  input  logic                  spi_done,
  input  logic [DW-1:0]         spi_rd_data
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] gnt_d, req_done_d, req_err_d;
  logic [DW-1:0]      rd_data_d, spi_cmd_d;
  logic               spi_wrt_d;

  logic [PW-1:0]      owner_next;
  logic               burst_active;
  logic [PW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;

  assign owner_next   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // A grant still held in IDLE means a locked burst is in progress.
  assign burst_active = |gnt;

  // If the burst owner has dropped req, arbitration restarts just past it in
  // the same IDLE cycle; pick_ptr is only consumed in IDLE.
  assign pick_ptr     = burst_active ? owner_next : rr_ptr_q;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wd_cnt_q    <= '0;
      lock_q      <= 1'b0;
      gnt         <= '0;
      req_done    <= '0;
      req_err     <= '0;
      rd_data     <= '0;
      spi_wrt     <= 1'b0;
      spi_cmd     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      lock_q      <= lock_d;
      gnt         <= gnt_d;
      req_done    <= req_done_d;
      req_err     <= req_err_d;
      rd_data     <= rd_data_d;
      spi_wrt     <= spi_wrt_d;
      spi_cmd     <= spi_cmd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    lock_d      = lock_q;
    gnt_d       = gnt;
    req_done_d  = '0;
    req_err_d   = '0;
    rd_data_d   = rd_data;
    spi_wrt_d   = 1'b0;
    spi_cmd_d   = spi_cmd;

    case (state_q)
      IDLE: begin
        if (burst_active && req[owner_q]) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          state_d     = ISSUE;
        end else begin
          if (burst_active) begin
            rr_ptr_d = owner_next;
          end
          if (pick_valid) begin
            gnt_d       = pick_onehot;
            owner_d     = pick_idx;
            burst_cnt_d = BW'(1);
            state_d     = ISSUE;
          end else begin
            gnt_d       = '0;
            burst_cnt_d = '0;
          end
        end
      end

      ISSUE: begin
        spi_cmd_d = cmd_in[owner_q*DW +: DW];
        spi_wrt_d = 1'b1;
        wd_cnt_d  = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
        // done takes precedence over an expiry in the same cycle
        if (spi_done) begin
          rd_data_d  = spi_rd_data;
          req_done_d = gnt;
          lock_d     = lock[owner_q];
          state_d    = GAP;
        end else if (wd_cnt_q == WDW'(TIMEOUT_CYC - 1)) begin
          rd_data_d  = '0;
          req_done_d = gnt;
          req_err_d  = gnt;
          // an aborted transaction always ends the burst
          lock_d     = 1'b0;
          state_d    = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
        if (!(lock_q && (burst_cnt_q < BW'(MAX_BURST)))) begin
          gnt_d       = '0;
          rr_ptr_d    = owner_next;
          burst_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arb.sv
// tb/tb_spi_bus_arb.sv - self-checking bench for spi_bus_arb

module tb_spi_bus_arb;

  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int MAXB = 4;
  localparam int TO   = 4096;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] cmd_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic [DW-1:0]   rd_data;
  logic            spi_wrt;
  logic [DW-1:0]   spi_cmd;
  logic            spi_done;
  logic [DW-1:0]   spi_rd_data;

  spi_bus_arb #(
    .NUM_REQ     (N),
    .DW          (DW),
    .MAX_BURST   (MAXB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .cmd_in      (cmd_in),
    .gnt         (gnt),
    .req_done    (req_done),
    .req_err     (req_err),
    .rd_data     (rd_data),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // SPI master model controls
  int          dly  = 3;
  bit          hang = 0;
  bit          spur = 0;
  logic [15:0] last_rd = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // which: 0 = spi_wrt, 1 = any req_done; n = negedges advanced
  task automatic wait_for(input int which, input int budget, output int n);
    bit hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? (spi_wrt == 1'b1) : (req_done != '0);
    end while (!hit && n < budget);
    if (!hit) begin
      n_vec++;
      n_mis++;
      $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
    end
  endtask

  // SPI master: done arrives dly cycles after the spi_wrt cycle
  initial begin
    int cnt;
    cnt         = 0;
    spi_done    = 1'b0;
    spi_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (spi_wrt) begin
        cnt = hang ? -1 : dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_done    = 1'b1;
          spi_rd_data = 16'($urandom);
          last_rd     = spi_rd_data;
        end
      end
      if (spur) begin
        spi_done = 1'b1;
        spur     = 1'b0;
      end
    end
  end

  // Reference model: transaction timeline scheduled in absolute cycle numbers.
  initial begin
    logic [N-1:0]  e_gnt, e_done, e_err, n_gnt, n_done, n_err;
    logic [DW-1:0] e_cmd, e_rd, n_cmd, n_rd;
    logic          e_wrt, n_wrt;
    int m_ptr, m_burst, m_held, m_win, t_issue, t_wrt, t_gap, next_decide, k, w, c;
    bit m_active, m_keep;
    e_gnt = '0; e_done = '0; e_err = '0; e_cmd = '0; e_rd = '0; e_wrt = 1'b0;
    m_ptr = 0; m_burst = 0; m_held = -1; m_win = 0; m_active = 0; m_keep = 0;
    t_issue = -1; t_wrt = -1; t_gap = -1; next_decide = -1;
    forever begin
      @(negedge clk);
      k = cyc;
      if (!rst_n) begin
        e_gnt = '0; e_done = '0; e_err = '0; e_cmd = '0; e_rd = '0; e_wrt = 1'b0;
        m_ptr = 0; m_burst = 0; m_held = -1; m_win = 0; m_active = 0; m_keep = 0;
        t_issue = -1; t_wrt = -1; t_gap = -1; next_decide = k + 1;
      end
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("req_done", 32'(req_done), 32'(e_done));
      check("req_err", 32'(req_err), 32'(e_err));
      check("spi_wrt", 32'(spi_wrt), 32'(e_wrt));
      check("spi_cmd", 32'(spi_cmd), 32'(e_cmd));
      check("rd_data", 32'(rd_data), 32'(e_rd));
      if (rst_n) begin
        n_gnt = e_gnt; n_cmd = e_cmd; n_rd = e_rd;
        n_wrt = 1'b0; n_done = '0; n_err = '0;
        if (k == next_decide) begin
          w = -1;
          if (m_held >= 0 && req[m_held]) begin
            w = m_held;
            m_burst++;
          end else begin
            if (m_held >= 0) begin
              m_ptr = (m_held + 1) % N; m_burst = 0; m_held = -1;
            end
            for (int i = 0; i < N; i++) begin
              c = (m_ptr + i) % N;
              if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) m_burst = 1;
          end
          if (w >= 0) begin
            m_win = w; n_gnt = '0; n_gnt[w] = 1'b1;
            t_issue = k + 1; t_wrt = k + 2; m_active = 1; next_decide = -1;
          end else begin
            n_gnt = '0; next_decide = k + 1;
          end
        end
        if (m_active && k == t_issue) begin
          n_wrt = 1'b1;
          n_cmd = cmd_in[m_win*DW +: DW];
        end
        if (m_active && k >= t_wrt && (spi_done || k == t_wrt + TO - 1)) begin
          n_done[m_win] = 1'b1;
          n_err[m_win]  = !spi_done;
          n_rd          = spi_done ? spi_rd_data : '0;
          m_keep        = spi_done && lock[m_win] && (m_burst < MAXB);
          m_active = 0; t_gap = k + 1; next_decide = k + 2;
        end
        if (k == t_gap) begin
          if (m_keep) begin
            m_held = m_win;
          end else begin
            n_gnt = '0; m_ptr = (m_win + 1) % N; m_burst = 0; m_held = -1;
          end
        end
        e_gnt = n_gnt; e_done = n_done; e_err = n_err;
        e_wrt = n_wrt; e_cmd = n_cmd; e_rd = n_rd;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; req = '0; lock = '0; hang = 0; dly = 3;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq2 [4];
    logic [1:0] seq3 [6];
    int n;
    rst_n  = 1'b0;
    req    = '0;
    lock   = '0;
    cmd_in = {16'h1234, 16'h0800};
    seq2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    seq3 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    // 1: single transaction latency and data return
    do_reset();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    dly = 40; req = 2'b01;
    @(negedge clk);
    wait_for(0, 10, n);
    check("t1_req_to_wrt", 32'(n), 32'd2);
    check("t1_spi_cmd", 32'(spi_cmd), 32'h0800);
    check("t1_gnt", 32'(gnt), 32'h1);
    wait_for(1, 100, n);
    check("t1_wrt_to_done", 32'(n), 32'd41);
    check("t1_req_done", 32'(req_done), 32'h1);
    check("t1_req_err", 32'(req_err), 32'h0);
    check("t1_rd_data", 32'(rd_data), 32'(last_rd));

    // 2: plain alternation
    do_reset();
    dly = 3; lock = 2'b00; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 100, n);
      check("t2_gnt_seq", 32'(gnt), 32'(seq2[i]));
      check("t2_cmd_seq", 32'(spi_cmd), (seq2[i] == 2'b01) ? 32'h0800 : 32'h1234);
    end

    // 3: locked burst capped at four
    do_reset();
    dly = 3; lock = 2'b01; req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_for(0, 100, n);
      check("t3_gnt_seq", 32'(gnt), 32'(seq3[i]));
    end

    // 4: watchdog abort, then the other requester is served
    do_reset();
    hang = 1; lock = 2'b00; req = 2'b11;
    wait_for(0, 10, n);
    check("t4_gnt", 32'(gnt), 32'h1);
    hang = 0;
    wait_for(1, 5000, n);
    check("t4_wrt_to_abort", 32'(n), 32'd4096);
    check("t4_req_done", 32'(req_done), 32'h1);
    check("t4_req_err", 32'(req_err), 32'h1);
    check("t4_rd_data", 32'(rd_data), 32'h0);
    wait_for(0, 10, n);
    check("t4_next_gnt", 32'(gnt), 32'h2);
    wait_for(1, 100, n);
    check("t4_next_err", 32'(req_err), 32'h0);

    // 5: spurious done in IDLE, then reset during WAIT
    do_reset();
    spur = 1;
    repeat (6) begin
      @(negedge clk);
      check("t5_spurious_done", 32'(req_done), 32'h0);
    end
    @(posedge clk);
    #1;
    dly = 20; req = 2'b01;
    @(negedge clk);
    wait_for(0, 10, n);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_wrt", 32'(spi_wrt), 32'h0);
    check("t5_rst_cmd", 32'(spi_cmd), 32'h0);
    check("t5_rst_done", 32'(req_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    wait_for(0, 10, n);
    check("t5_restart_latency", 32'(n), 32'd2);

    // 6: done on the exact watchdog-expiry cycle
    do_reset();
    dly = TO - 1; req = 2'b01;
    wait_for(0, 10, n);
    wait_for(1, 5000, n);
    check("t6_wrt_to_done", 32'(n), 32'd4096);
    check("t6_req_done", 32'(req_done), 32'h1);
    check("t6_req_err", 32'(req_err), 32'h0);
    check("t6_rd_data", 32'(rd_data), 32'(last_rd));

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) req = 2'($urandom);
      lock   = 2'($urandom);
      cmd_in = $urandom;
      dly    = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) spur = 1;
    end
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
    $fatal(1);
  end

endmodule
